uart_byte_rx: RTL and testbench

//  Oversampling 8N1 UART receiver, directly upstream of the RAM write bridge.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_byte_rx.sv | 144 ++++++++++++++
 tb/tb_uart_byte_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//  Types and constants shared by the UART receive and transmit sides.
//  - rx_state_t             : receiver frame state
//  - DEFAULT_CLOCKS_PER_BAUD: clock cycles per serial bit
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_CLOCKS_PER_BAUD = 33;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//  Two-flop synchroniser for a single asynchronous input. Both flops reset
//  to 1, so an idle-high line does not produce a false edge after reset.
//  Ports:
//   clk_in  in  1  destination clock
//   rst_in  in  1  synchronous, active-low reset
//   d_in    in  1  asynchronous input
//   q_out   out 1  synchronised copy of d_in (2-cycle latency)
module sync_2ff (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d_in,
  output logic q_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign q_out = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx
//  Oversampling 8N1 UART receiver. The rx pin is synchronised, the start
//  bit is confirmed at mid-bit, 8 data bits are sampled LSB-first at the
//  middle of each bit, and the stop bit is checked. A good byte produces a
//  one-cycle valid_out pulse; a low stop bit produces a one-cycle
//  framing_err_out pulse instead.
//  Ports:
//   clk_in           in  1  system clock
//   rst_in           in  1  synchronous, active-low reset
//   rx_in            in  1  asynchronous serial line, idle high
//   data_out         out 8  last good byte, held until the next one
//   valid_out        out 1  one-cycle pulse, data_out is new
//   framing_err_out  out 1  one-cycle pulse, stop bit was low
//   busy_out         out 1  receiver is inside a frame
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       framing_err_out,
  output logic       busy_out
);

  localparam int HALF = CLOCKS_PER_BAUD / 2;
  localparam int CW   = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CLOCKS_PER_BAUD - 1);

  logic rx_s;
  logic rx_d_q;

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  sync_2ff u_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d_in   (rx_in),
    .q_out  (rx_s)
  );

  // The sample point is the cycle in which the down-counter sits at zero.
  logic sample;
  logic fall;
  assign sample = (cnt_q == '0);
  assign fall   = rx_d_q && !rx_s;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A held-low line (break) never re-arms here: a real 1->0 edge is needed.
        if (fall) begin
          state_d = START;
          cnt_d   = HALF_M1;
        end
      end
      START: begin
        if (sample) begin
          if (!rx_s) begin
            state_d   = DATA;
            cnt_d     = CPB_M1;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;  // start bit gone by mid-bit: glitch
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = CPB_M1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rx_d_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_d_q    <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out        = data_q;
  assign valid_out       = valid_q;
  assign framing_err_out = ferr_q;
  assign busy_out        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx
//  Drives 8N1 frames into uart_byte_rx. Each expected output event (kind,
//  byte, cycle) is queued when its frame is driven; a negedge monitor
//  records every observed pulse, and each test pops and compares.
module tb_uart_byte_rx;

  localparam int CPB = 33;

  typedef struct {
    logic [1:0] kind;   // 2'b01 valid, 2'b10 framing error, 2'b11 both
    logic [7:0] data;
    int         cyc;    // -1: cycle not checked
  } ev_t;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       rx_in  = 1'b1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       framing_err_out;
  logic       busy_out;

  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  ev_t exp_q[$];
  ev_t obs_q[$];

  uart_byte_rx #(.CLOCKS_PER_BAUD(CPB)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rx_in           (rx_in),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .framing_err_out (framing_err_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (valid_out || framing_err_out) begin
      obs_q.push_back('{kind: {framing_err_out, valid_out}, data: data_out, cyc: cyc});
    end
  end

  // Leaves the caller 1 time unit after a posedge, line high.
  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    do @(negedge clk_in); while (cyc < t);
  endtask

  // Starts at the current time (1 unit after a posedge); ends likewise, so
  // consecutive calls produce back-to-back frames with no gap.
  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_val,
                            output int start_cyc);
    logic [9:0] fr;
    fr = {stop_val, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_in = fr[i];
      repeat (bt) @(posedge clk_in);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    rx_in  = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", data_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", valid_out); end
    n_cmp++; if (framing_err_out !== 1'b0) begin n_bad++; $display("FAIL reset_ferr got %b want 0", framing_err_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy_out); end
    rst_in = 1'b1;
    idle(10);
    obs_q.delete();
    $display("test_reset done");
  endtask

  task automatic test_single_byte();
    int s;
    ev_t e, o;
    idle(5);
    send_frame(8'h57, CPB, 1'b1, s);
    exp_q.push_back('{kind: 2'b01, data: 8'h57, cyc: s + 2 + CPB/2 + 9*CPB + 1});
    idle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL single_missing got none want kind %b data %h", e.kind, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_bad++; $display("FAIL single got kind %b data %h cyc %0d want kind %b data %h cyc %0d",
                            o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end else $display("single: byte %h at cycle %0d", o.data, o.cyc);
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL single_extra got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int s0, s1;
    ev_t e, o;
    idle(5);
    send_frame(8'h00, CPB, 1'b1, s0);
    send_frame(8'hFF, CPB, 1'b1, s1);
    exp_q.push_back('{kind: 2'b01, data: 8'h00, cyc: s0 + 316});
    exp_q.push_back('{kind: 2'b01, data: 8'hFF, cyc: s0 + 316 + 330});
    idle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_missing got none want data %h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_bad++; $display("FAIL b2b got kind %b data %h cyc %0d want kind %b data %h cyc %0d",
                            o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end else $display("b2b: byte %h at cycle %0d", o.data, o.cyc);
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL b2b_extra got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_glitch();
    int s;
    idle(5);
    s = cyc;
    rx_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    rx_in = 1'b1;
    wait_cyc(s + 2 + CPB/2);
    n_cmp++; if (busy_out !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_hi got %b want 1", busy_out); end
    wait_cyc(s + 3 + CPB/2);
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_lo got %b want 0", busy_out); end
    idle(400);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL glitch_events got %0d want 0", obs_q.size()); end
    else $display("glitch: rejected, no pulse");
    obs_q.delete();
  endtask

  task automatic test_framing();
    int s, s2;
    ev_t e, o;
    idle(5);
    send_frame(8'hA5, CPB, 1'b0, s);   // line stays low after the frame
    exp_q.push_back('{kind: 2'b10, data: 8'hFF, cyc: s + 316});
    repeat (20*CPB) @(posedge clk_in);
    #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL break_busy got %b want 0", busy_out); end
    idle(40);
    send_frame(8'h3C, CPB, 1'b1, s2);
    exp_q.push_back('{kind: 2'b01, data: 8'h3C, cyc: s2 + 316});
    idle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL framing_missing got none want kind %b", e.kind);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_bad++; $display("FAIL framing got kind %b data %h cyc %0d want kind %b data %h cyc %0d",
                            o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end else $display("framing: kind %b data %h at cycle %0d", o.kind, o.data, o.cyc);
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL framing_extra got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [4:0] head;
    int s;
    ev_t e, o;
    idle(5);
    head = {4'b0001, 1'b0};  // start bit then bits 0..3 of 0x81
    for (int i = 0; i < 5; i++) begin
      rx_in = head[i];
      repeat (CPB) @(posedge clk_in);
      #1;
    end
    rx_in = 1'b0;            // bit 4 of 0x81
    repeat (CPB/2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    rx_in  = 1'b1;           // sender abandons the frame
    @(posedge clk_in);
    #1;
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL midrst_data got %h want 00", data_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy_out); end
    n_cmp++; if (valid_out !== 1'b0 || framing_err_out !== 1'b0) begin
      n_bad++; $display("FAIL midrst_pulses got %b%b want 00", valid_out, framing_err_out);
    end
    rst_in = 1'b1;
    idle(400);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midrst_events got %0d want 0", obs_q.size()); end
    obs_q.delete();
    send_frame(8'h42, CPB, 1'b1, s);
    exp_q.push_back('{kind: 2'b01, data: 8'h42, cyc: s + 316});
    idle(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL midrst_missing got none want data %h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data || o.cyc != e.cyc) begin
          n_bad++; $display("FAIL midrst got kind %b data %h cyc %0d want kind %b data %h cyc %0d",
                            o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
        end else $display("midrst: byte %h at cycle %0d", o.data, o.cyc);
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midrst_extra got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_baud_sweep();
    int bts[2];
    logic [7:0] bytes[2];
    int s;
    ev_t e, o;
    bts[0] = 32; bts[1] = 34;
    bytes[0] = 8'h55; bytes[1] = 8'hAA;
    foreach (bts[i]) begin
      foreach (bytes[j]) begin
        idle(5);
        send_frame(bytes[j], bts[i], 1'b1, s);
        exp_q.push_back('{kind: 2'b01, data: bytes[j], cyc: -1});
      end
    end
    idle(40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_q.size() == 0) begin
        n_bad++; $display("FAIL sweep_missing got none want data %h", e.data);
      end else begin
        o = obs_q.pop_front();
        if (o.kind !== e.kind || o.data !== e.data) begin
          n_bad++; $display("FAIL sweep got kind %b data %h want kind %b data %h",
                            o.kind, o.data, e.kind, e.data);
        end else $display("sweep: byte %h at cycle %0d", o.data, o.cyc);
      end
    end
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL sweep_extra got %0d events want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_mid_reset();
    test_baud_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
